mul_div_unit: RTL and testbench

//   Iterative RV32M multiply/divide unit; companion to the combinational ALU in the execute stage.

---
 rtl/mul_div_unit.sv | 163 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU one bit per cycle on operand
// magnitudes; the result sign is applied once, when the final step completes.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   MD_Start     request, accepted in IDLE when MD_Kill is low
//   MD_OP        RV32M funct3 of the operation
//   MD_In_A/B    operands (rs1/rs2), sampled only on acceptance
//   MD_Kill      flush: abandon the operation in flight
//   MD_Busy      high while state != IDLE
//   MD_Done      one-cycle completion pulse
//   MD_Out       result register, held until the next completion or reset
module mul_div_unit #(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MD_Start,
  input  logic [2:0]        MD_OP,
  input  logic [DWIDTH-1:0] MD_In_A,
  input  logic [DWIDTH-1:0] MD_In_B,
  input  logic              MD_Kill,
  output logic              MD_Busy,
  output logic              MD_Done,
  output logic [DWIDTH-1:0] MD_Out
);

  localparam int unsigned       CntW    = $clog2(DWIDTH);
  localparam logic [CntW-1:0]   LastCnt = CntW'(DWIDTH - 1);
  localparam logic [DWIDTH-1:0] MinNeg  = {1'b1, {(DWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q;
  logic [2:0]        op_q;
  logic [DWIDTH-1:0] hi_q;      // mul: product high half; div: partial remainder
  logic [DWIDTH-1:0] lo_q;      // mul: multiplier / product low half; div: dividend / quotient
  logic [DWIDTH-1:0] b_q;       // |B|: multiplicand or divisor
  logic              neg_q;     // product / quotient sign
  logic              rem_neg_q; // remainder takes the dividend's sign
  logic [CntW-1:0]   cnt_q;
  logic              done_q;
  logic [DWIDTH-1:0] out_q;

  // Operand decode for the incoming request.
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [DWIDTH-1:0] a_mag, b_mag;
  logic              div_zero, div_ovf;
  logic [DWIDTH-1:0] special_res;

  always_comb begin
    a_signed = (MD_OP != 3'b011) && (MD_OP != 3'b101) && (MD_OP != 3'b111);
    b_signed = a_signed && (MD_OP != 3'b010);
    a_neg    = a_signed && MD_In_A[DWIDTH-1];
    b_neg    = b_signed && MD_In_B[DWIDTH-1];
    a_mag    = a_neg ? -MD_In_A : MD_In_A;
    b_mag    = b_neg ? -MD_In_B : MD_In_B;
    div_zero = MD_OP[2] && (MD_In_B == '0);
    // Only signed DIV/REM can overflow.
    div_ovf  = MD_OP[2] && !MD_OP[0] && (MD_In_A == MinNeg) && (MD_In_B == '1);
    special_res = '0;
    if (div_zero) begin
      special_res = MD_OP[1] ? MD_In_A : '1;
    end else if (div_ovf) begin
      special_res = MD_OP[1] ? '0 : MinNeg;
    end
  end

  // One iteration of the datapath plus the sign-corrected result of that step.
  logic [DWIDTH:0]     sum, trial;
  logic [DWIDTH-1:0]   hi_step, lo_step;
  logic [2*DWIDTH-1:0] prod_fin;
  logic [DWIDTH-1:0]   quo_fin, rem_fin, calc_res;

  always_comb begin
    sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(DWIDTH+1){1'b0}});
    // Shifted-in remainder needs DWIDTH+1 bits; the top bit doubles as the borrow.
    trial = {hi_q, lo_q[DWIDTH-1]} - {1'b0, b_q};
    if (op_q[2]) begin
      if (!trial[DWIDTH]) begin
        hi_step = trial[DWIDTH-1:0];
        lo_step = {lo_q[DWIDTH-2:0], 1'b1};
      end else begin
        hi_step = {hi_q[DWIDTH-2:0], lo_q[DWIDTH-1]};
        lo_step = {lo_q[DWIDTH-2:0], 1'b0};
      end
    end else begin
      hi_step = sum[DWIDTH:1];
      lo_step = {sum[0], lo_q[DWIDTH-1:1]};
    end
    prod_fin = neg_q ? -{hi_step, lo_step} : {hi_step, lo_step};
    quo_fin  = neg_q ? -lo_step : lo_step;
    rem_fin  = rem_neg_q ? -hi_step : hi_step;
    if (op_q[2]) begin
      calc_res = op_q[1] ? rem_fin : quo_fin;
    end else if (op_q[1:0] == 2'b00) begin
      calc_res = prod_fin[DWIDTH-1:0];
    end else begin
      calc_res = prod_fin[2*DWIDTH-1:DWIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      out_q     <= '0;
    end else begin
      // The pulse follows the DONE cycle, so a kill seen in DONE cannot cancel it.
      done_q <= (state_q == StDone);
      unique case (state_q)
        StIdle: begin
          if (MD_Start && !MD_Kill) begin
            op_q      <= MD_OP;
            hi_q      <= '0;
            lo_q      <= a_mag;
            b_q       <= b_mag;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            cnt_q     <= '0;
            if (div_zero || div_ovf) begin
              out_q   <= special_res;
              state_q <= StDone;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          if (MD_Kill) begin
            state_q <= StIdle;
          end else begin
            hi_q  <= hi_step;
            lo_q  <= lo_step;
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
              out_q   <= calc_res;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign MD_Busy = (state_q != StIdle);
  assign MD_Done = done_q;
  assign MD_Out  = out_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  localparam int unsigned W = 32;
  localparam logic [31:0] MinNeg = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          MD_Start;
  logic [2:0]    MD_OP;
  logic [W-1:0]  MD_In_A;
  logic [W-1:0]  MD_In_B;
  logic          MD_Kill;
  logic          MD_Busy;
  logic          MD_Done;
  logic [W-1:0]  MD_Out;

  mul_div_unit #(.DWIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .MD_Start (MD_Start),
    .MD_OP    (MD_OP),
    .MD_In_A  (MD_In_A),
    .MD_In_B  (MD_In_B),
    .MD_Kill  (MD_Kill),
    .MD_Busy  (MD_Busy),
    .MD_Done  (MD_Done),
    .MD_Out   (MD_Out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_out;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the RISC-V M-extension definitions.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, ps;
    logic [63:0]        pu;
    logic signed [31:0] qa, qb;
    logic               ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    qa  = $signed(a);
    qb  = $signed(b);
    ovf = (a == MinNeg) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin ps = sa * sb; return ps[31:0]; end
      3'd1: begin ps = sa * sb; return ps[63:32]; end
      3'd2: begin ps = sa * $signed({32'd0, b}); return ps[63:32]; end
      3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return MinNeg;
        return qa / qb;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return qa % qb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (op[2] && (b == 0)) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == MinNeg && b == 32'hFFFF_FFFF) return 1;
    return W + 1;
  endfunction

  // Present a request for one edge; returns at the negedge after acceptance.
  task automatic accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    MD_Start = 1'b1;
    MD_OP    = op;
    MD_In_A  = a;
    MD_In_B  = b;
    @(negedge clk);
    MD_Start = 1'b0;
    MD_In_A  = $urandom;
    MD_In_B  = $urandom;
    MD_OP    = 3'($urandom_range(0, 7));
  endtask

  // Counts edges until MD_Done, starting from 'n_in' edges after acceptance.
  task automatic wait_done(input int n_in, output int n, output bit busy_ok);
    n = n_in;
    busy_ok = 1'b1;
    while (!MD_Done && n < 60) begin
      if (!MD_Busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name);
    int n;
    bit busy_ok;
    accept(op, a, b);
    wait_done(0, n, busy_ok);
    check({name, " latency"}, 64'(n), 64'(lat));
    check({name, " busy"}, 64'(busy_ok), 64'd1);
    check({name, " result"}, 64'(MD_Out), 64'(exp));
    @(negedge clk);
    check({name, " pulse width"}, 64'(MD_Done), 64'd0);
    check({name, " held"}, 64'(MD_Out), 64'(exp));
    last_out = exp;
  endtask

  task automatic watch_no_done(input int cycles, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (MD_Done) seen = 1'b1;
    end
    check({name, " no done"}, 64'(seen), 64'd0);
  endtask

  initial begin
    int n;
    bit busy_ok;
    reset    = 1'b1;
    MD_Start = 1'b0;
    MD_Kill  = 1'b0;
    MD_OP    = 3'd0;
    MD_In_A  = '0;
    MD_In_B  = '0;
    last_out = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(MD_Busy), 64'd0);
    check("reset done", 64'(MD_Done), 64'd0);
    check("reset out", 64'(MD_Out), 64'd0);
    reset = 1'b0;

    vecs.push_back('{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul 7*-3"});
    vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh min*min"});
    vecs.push_back('{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulhu"});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, "mulhsu -1*2"});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu max"});
    vecs.push_back('{3'd0, 32'd12345,     32'd0,         32'd0,         33, "mul by 0"});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div -7/2"});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "rem -7%2"});
    vecs.push_back('{3'd5, 32'd100,       32'd7,         32'd14,        33, "divu 100/7"});
    vecs.push_back('{3'd7, 32'd100,       32'd7,         32'd2,         33, "remu 100%7"});
    vecs.push_back('{3'd5, 32'h1234,      32'd0,         32'hFFFF_FFFF, 1,  "divu by 0"});
    vecs.push_back('{3'd6, 32'h1234,      32'd0,         32'h1234,      1,  "rem by 0"});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div ovf"});
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  "rem ovf"});
    vecs.push_back('{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33, "divu no ovf"});
    vecs.push_back('{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, "remu no ovf"});

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                             vecs[i].name);

    // Kill at iteration 10: no completion, output untouched.
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "pre-kill mul");
    accept(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    MD_Kill = 1'b1;
    @(negedge clk);
    MD_Kill = 1'b0;
    check("kill busy", 64'(MD_Busy), 64'd0);
    watch_no_done(40, "kill");
    check("kill out", 64'(MD_Out), 64'(last_out));

    // Kill together with start in IDLE: nothing accepted.
    @(negedge clk);
    MD_Start = 1'b1;
    MD_Kill  = 1'b1;
    MD_OP    = 3'd5;
    MD_In_A  = 32'd9;
    MD_In_B  = 32'd0;
    @(negedge clk);
    MD_Start = 1'b0;
    MD_Kill  = 1'b0;
    check("kill+start busy", 64'(MD_Busy), 64'd0);
    watch_no_done(5, "kill+start");

    // Kill in DONE does not cancel the pulse.
    accept(3'd5, 32'h1234, 32'd0);
    MD_Kill = 1'b1;
    @(negedge clk);
    MD_Kill = 1'b0;
    check("kill in done pulse", 64'(MD_Done), 64'd1);
    check("kill in done out", 64'(MD_Out), 64'hFFFF_FFFF);
    last_out = 32'hFFFF_FFFF;

    // Second start while busy is ignored.
    accept(3'd5, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    MD_Start = 1'b1;
    MD_OP    = 3'd0;
    MD_In_A  = 32'd3;
    MD_In_B  = 32'd3;
    @(negedge clk);
    MD_Start = 1'b0;
    wait_done(6, n, busy_ok);
    check("busy start latency", 64'(n), 64'd33);
    check("busy start result", 64'(MD_Out), 64'd14);
    watch_no_done(40, "busy start");

    // Reset in the middle of an operation.
    accept(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid reset busy", 64'(MD_Busy), 64'd0);
    check("mid reset done", 64'(MD_Done), 64'd0);
    check("mid reset out", 64'(MD_Out), 64'd0);
    watch_no_done(40, "mid reset");

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int          sel;
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = MinNeg; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      else if (sel == 3) a = 32'($urandom_range(0, 255));
      run_op(op, a, b, model(op, a, b), model_lat(op, a, b),
             $sformatf("rand%0d op%0d a=%h b=%h", i, op, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
